// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, funct
// codes and the datapath select/ALU codes the datapath also decodes.
package mc_controller_pkg;

  localparam logic [3:0] S_FETCH1  = 4'd0;
  localparam logic [3:0] S_FETCH2  = 4'd1;
  localparam logic [3:0] S_FETCH3  = 4'd2;
  localparam logic [3:0] S_FETCH4  = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_MEMADR  = 4'd5;
  localparam logic [3:0] S_LBRD    = 4'd6;
  localparam logic [3:0] S_LBWR    = 4'd7;
  localparam logic [3:0] S_SBWR    = 4'd8;
  localparam logic [3:0] S_RTYPEEX = 4'd9;
  localparam logic [3:0] S_RTYPEWR = 4'd10;
  localparam logic [3:0] S_BEQEX   = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;
  localparam logic [3:0] S_ADDIEX  = 4'd13;
  localparam logic [3:0] S_ADDIWR  = 4'd14;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // bit2 inverts B with carry-in; [1:0] picks AND/OR/SUM/SLT
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       pcen;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// R-type funct to ALU operation decode; unknown functs fall back to add.
module mc_aludec
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    case (funct)
      F_ADD:   alucontrol = ALU_ADD;
      F_SUB:   alucontrol = ALU_SUB;
      F_AND:   alucontrol = ALU_AND;
      F_OR:    alucontrol = ALU_OR;
      F_SLT:   alucontrol = ALU_SLT;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: four byte-wide fetch cycles, decode, then per-opcode
// execute/writeback. Outputs are Moore except pcen in BEQEX, which follows zero.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic [3:0] state
);

  logic [3:0] next;
  logic [2:0] rtype_alu;
  ctrl_t      c;

  mc_aludec u_aludec (
    .funct      (funct),
    .alucontrol (rtype_alu)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH1;
    else          state <= next;
  end

  always_comb begin
    next = S_FETCH1;
    case (state)
      S_FETCH1:  next = S_FETCH2;
      S_FETCH2:  next = S_FETCH3;
      S_FETCH3:  next = S_FETCH4;
      S_FETCH4:  next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: next = S_MEMADR;
          OP_RTYPE:     next = S_RTYPEEX;
          OP_BEQ:       next = S_BEQEX;
          OP_J:         next = S_JEX;
          OP_ADDI:      next = S_ADDIEX;
          default:      next = S_FETCH1;
        endcase
      end
      S_MEMADR:  next = (op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:    next = S_LBWR;
      S_RTYPEEX: next = S_RTYPEWR;
      S_ADDIEX:  next = S_ADDIWR;
      default:   next = S_FETCH1;
    endcase
  end

  always_comb begin
    c            = '0;
    c.alucontrol = ALU_ADD;
    case (state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        // fetch states are encoded 0..3, so the low bits select the IR byte
        c.memread = 1'b1;
        c.irwrite = 4'b0001 << state[1:0];
        c.alusrcb = SRCB_ONE;
        c.pcen    = 1'b1;
      end
      S_DECODE:  c.alusrcb = SRCB_BOFF;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_LBRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_SBWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_RT;
        c.alucontrol = rtype_alu;
      end
      S_RTYPEWR: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_RT;
        c.alucontrol = ALU_SUB;
        c.pcsource   = PC_ALUOUT;
        c.pcen       = zero;
      end
      S_JEX: begin
        c.pcsource = PC_JUMP;
        c.pcen     = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_ADDIWR:  c.regwrite = 1'b1;
      default: ;
    endcase
  end

  // Strobes are gated so nothing writes while reset is held, even though the
  // state register already sits in FETCH1.
  assign memread    = c.memread;
  assign memwrite   = c.memwrite & reset_n;
  assign iord       = c.iord;
  assign irwrite    = c.irwrite & {4{reset_n}};
  assign alusrca    = c.alusrca;
  assign alusrcb    = c.alusrcb;
  assign alucontrol = c.alucontrol;
  assign regwrite   = c.regwrite & reset_n;
  assign regdst     = c.regdst;
  assign memtoreg   = c.memtoreg;
  assign pcen       = c.pcen & reset_n;
  assign pcsource   = c.pcsource;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench: the driver pushes the expected per-cycle control word for
// each instruction; a negedge monitor pops and compares.
module tb_mc_controller;
  import mc_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       memread, memwrite, iord, alusrca, regwrite, regdst, memtoreg, pcen;
  logic [3:0] irwrite, state;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucontrol;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .pcen(pcen), .pcsource(pcsource), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       memread, memwrite, iord;
    logic [3:0] irwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regwrite, regdst, memtoreg, pcen;
    logic [1:0] pcsource;
  } obs_t;

  obs_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Steps after DECODE for each instruction class; illegal ops have none.
  function automatic int tail_len(input logic [5:0] o);
    case (o)
      OP_LB:           return 3;
      OP_SB, OP_RTYPE: return 2;
      OP_ADDI:         return 2;
      OP_BEQ, OP_J:    return 1;
      default:         return 0;
    endcase
  endfunction

  function automatic logic [3:0] step_state(input logic [5:0] o, input int k);
    logic [3:0] fetch_seq [5];
    fetch_seq = '{S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_DECODE};
    if (k < 5) return fetch_seq[k];
    case (o)
      OP_LB:    return (k == 5) ? S_MEMADR  : (k == 6) ? S_LBRD : S_LBWR;
      OP_SB:    return (k == 5) ? S_MEMADR  : S_SBWR;
      OP_RTYPE: return (k == 5) ? S_RTYPEEX : S_RTYPEWR;
      OP_ADDI:  return (k == 5) ? S_ADDIEX  : S_ADDIWR;
      OP_BEQ:   return S_BEQEX;
      default:  return S_JEX;
    endcase
  endfunction

  function automatic obs_t expect_obs(input logic [3:0] s, input logic [5:0] f, input logic z);
    obs_t e;
    e = '0;
    e.state = s;
    e.alucontrol = 3'b010;
    case (s)
      S_FETCH1: begin e.memread = 1; e.irwrite = 4'b0001; e.alusrcb = 2'b01; e.pcen = 1; end
      S_FETCH2: begin e.memread = 1; e.irwrite = 4'b0010; e.alusrcb = 2'b01; e.pcen = 1; end
      S_FETCH3: begin e.memread = 1; e.irwrite = 4'b0100; e.alusrcb = 2'b01; e.pcen = 1; end
      S_FETCH4: begin e.memread = 1; e.irwrite = 4'b1000; e.alusrcb = 2'b01; e.pcen = 1; end
      S_DECODE: e.alusrcb = 2'b11;
      S_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_LBRD:   begin e.memread = 1; e.iord = 1; end
      S_LBWR:   begin e.regwrite = 1; e.memtoreg = 1; end
      S_SBWR:   begin e.memwrite = 1; e.iord = 1; end
      S_RTYPEEX: begin
        e.alusrca = 1;
        case (f)
          6'b100010: e.alucontrol = 3'b110;
          6'b100100: e.alucontrol = 3'b000;
          6'b100101: e.alucontrol = 3'b001;
          6'b101010: e.alucontrol = 3'b111;
          default:   e.alucontrol = 3'b010;
        endcase
      end
      S_RTYPEWR: begin e.regwrite = 1; e.regdst = 1; end
      S_BEQEX:   begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsource = 2'b01; e.pcen = z; end
      S_JEX:     begin e.pcsource = 2'b10; e.pcen = 1; end
      S_ADDIEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_ADDIWR:  e.regwrite = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Entered at posedge+1 while the DUT sits in FETCH1; returns at posedge+1
  // of the following FETCH1. zmode: 0/1 force zero, 2 random.
  task automatic run_inst(input logic [5:0] o, input logic [5:0] f, input int zmode);
    int n;
    n = 5 + tail_len(o);
    op = o;
    funct = f;
    for (int k = 0; k < n; k++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      expq.push_back(expect_obs(step_state(o, k), f, zero));
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a.state = state; a.memread = memread; a.memwrite = memwrite; a.iord = iord;
      a.irwrite = irwrite; a.alusrca = alusrca; a.alusrcb = alusrcb;
      a.alucontrol = alucontrol; a.regwrite = regwrite; a.regdst = regdst;
      a.memtoreg = memtoreg; a.pcen = pcen; a.pcsource = pcsource;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_ctrl act=%h exp=%h (state act=%0d exp=%0d)", a, e, a.state, e.state);
      end
      checks++;
      if (memwrite && regwrite) begin
        failures++;
        $display("FAIL mw_rw_excl act=11 exp=not both");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  function automatic logic [5:0] rand_illegal();
    logic [5:0] o;
    do o = 6'($urandom);
    while (o == OP_LB || o == OP_SB || o == OP_RTYPE || o == OP_BEQ || o == OP_J || o == OP_ADDI);
    return o;
  endfunction

  initial begin
    logic [5:0] fl [5];
    logic [5:0] o, f;
    fl = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
    #2;
    chk("rst_state",    32'(state),    32'(S_FETCH1));
    chk("rst_irwrite",  32'(irwrite),  32'h0);
    chk("rst_pcen",     32'(pcen),     32'h0);
    chk("rst_strobes",  32'({memwrite, regwrite}), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // directed cases
    run_inst(OP_RTYPE, F_SUB, 2);
    run_inst(OP_RTYPE, F_SLT, 2);
    run_inst(OP_RTYPE, 6'b000000, 2);
    run_inst(OP_BEQ, 6'h00, 1);
    run_inst(OP_BEQ, 6'h00, 0);
    run_inst(OP_LB, 6'h15, 2);
    run_inst(OP_SB, 6'h2a, 2);
    run_inst(OP_J, 6'h00, 2);
    run_inst(6'b111111, 6'h00, 2);
    run_inst(OP_ADDI, 6'h00, 2);

    // reset pulse in ADDIWR: walk FETCH1..ADDIEX through the scoreboard
    op = OP_ADDI;
    for (int k = 0; k < 6; k++) begin
      zero = 1'($urandom_range(0, 1));
      expq.push_back(expect_obs(step_state(OP_ADDI, k), funct, zero));
      @(posedge clk); #1;
    end
    chk("pre_rst_addiwr", 32'(state), 32'(S_ADDIWR));
    reset_n = 1'b0;
    #1;
    chk("midrst_state",    32'(state),    32'(S_FETCH1));
    chk("midrst_regwrite", 32'(regwrite), 32'h0);
    chk("midrst_irwrite",  32'(irwrite),  32'h0);
    chk("midrst_pcen",     32'(pcen),     32'h0);
    @(posedge clk); #1;
    chk("held_rst_state",  32'(state),    32'(S_FETCH1));
    reset_n = 1'b1;
    #1;
    chk("rel_memread",  32'(memread), 32'h1);
    chk("rel_irwrite",  32'(irwrite), 32'h1);
    run_inst(OP_J, 6'h00, 2);

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 7))
        0: o = OP_LB;
        1: o = OP_SB;
        2: o = OP_RTYPE;
        3: o = OP_BEQ;
        4: o = OP_J;
        5: o = OP_ADDI;
        default: o = rand_illegal();
      endcase
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
      run_inst(o, f, 2);
    end

    @(negedge clk); #1;
    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one asynchronous active-low reset, reset_n; all ports below are 1 bit unless stated.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  opcode field of the assembled instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag, combinational in the same cycle.
REQ-007 memread, memwrite, iord  output  memory read strobe, memory write strobe, and address select (0 = PC, 1 = ALU out).
REQ-008 irwrite  output  4  one-hot byte enable into the 32-bit instruction register; bit i loads byte i.
REQ-009 alusrca, alusrcb  output  1, 2  ALU A select (0 = PC, 1 = rs) and B select (00 = rt, 01 = const 1, 10 = imm, 11 = branch offset).
REQ-010 alucontrol  output  3  ALU operation: bit2 inverts B and adds carry-in; [1:0] = 00 AND, 01 OR, 10 SUM, 11 SLT.
REQ-011 regwrite, regdst, memtoreg  output  register-file write, destination select (1 = rd, 0 = rt), and write-data select (1 = memory).
REQ-012 pcen, pcsource  output  1, 2  PC load enable and PC source select (00 = ALU, 01 = ALU out, 10 = jump).
REQ-013 state  output  4  current FSM state, for debug and verification only.

Function
REQ-014 The block SHALL be a 4-bit-encoded FSM with states FETCH1-4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, and ADDIWR.
REQ-015 Fetch sequence SHALL be FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE, unconditionally.
REQ-016 Each FETCHn SHALL assert memread=1, irwrite=1<<(n-1), alusrca=0, alusrcb=01, alucontrol=010, pcsource=00, and pcen=1.
REQ-017 DECODE SHALL assert alusrca=0, alusrcb=11, and alucontrol=010.
REQ-018 DECODE SHALL branch on op: 100000 (lb) or 101000 (sb) -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000010 -> JEX; 001000 -> ADDIEX; any other op -> FETCH1 with no side effects.
REQ-019 MEMADR SHALL assert alusrca=1, alusrcb=10, and alucontrol=010; next state is LBRD if op=100000, else SBWR.
REQ-020 LBRD SHALL assert memread=1 and iord=1, then go to LBWR.
REQ-021 LBWR SHALL assert regwrite=1, memtoreg=1, and regdst=0.
REQ-022 SBWR SHALL assert memwrite=1 and iord=1.
REQ-023 RTYPEEX SHALL assert alusrca=1, alusrcb=00, and alucontrol decoded from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
REQ-024 RTYPEWR SHALL assert regwrite=1, regdst=1, and memtoreg=0.
REQ-025 BEQEX SHALL assert alusrca=1, alusrcb=00, alucontrol=110, pcsource=01, and pcen=zero, combinationally in the same cycle.
REQ-026 JEX SHALL assert pcsource=10 and pcen=1.
REQ-027 ADDIEX SHALL assert alusrca=1, alusrcb=10, and alucontrol=010, then go to ADDIWR.
REQ-028 ADDIWR SHALL assert regwrite=1, regdst=0, and memtoreg=0.
REQ-029 LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR, and any unused encoding SHALL go to FETCH1.
REQ-030 Any output not listed for a state SHALL be 0; alucontrol not listed SHALL be 010.
REQ-031 All outputs except pcen in BEQEX SHALL be Moore, a function of state and op/funct only.
REQ-032 memwrite and regwrite SHALL never be asserted in the same cycle.
REQ-033 Instruction latencies, FETCH1 to the next FETCH1, SHALL be: lb 8 cycles, sb 7, R-type 7, addi 7, beq 6, j 6, illegal 5.

Reset
REQ-034 reset_n=0 SHALL force state=FETCH1 asynchronously, from any state including mid-instruction.
REQ-035 While reset_n=0, all write strobes (memwrite, regwrite, irwrite, pcen) SHALL be 0.
REQ-036 On the first rising clk after reset_n rises, the block SHALL perform FETCH1 actions, with FETCH1 outputs valid in that cycle.

Structure
REQ-037 A shared package SHALL hold the state encoding, opcode constants, funct constants, alucontrol codes, alusrcb codes, and pcsource codes; the ALU SHALL use the same alucontrol constants.
REQ-038 The funct-to-alucontrol decode SHALL be one combinational sub-module, mc_aludec; the FSM and output decode remain in mc_controller.

Verification
REQ-039 Reset: pulse reset_n low while in ADDIWR -> state=FETCH1 immediately and regwrite=0; after release -> memread=1 and irwrite=0001.
REQ-040 R-type: op=000000, funct=100010 -> RTYPEEX with alucontrol=110, then RTYPEWR with regwrite=1 and regdst=1; FETCH1 recurs after 7 cycles.
REQ-041 beq: op=000100 -> in BEQEX, zero=1 gives pcen=1 and pcsource=01; zero=0 gives pcen=0; FETCH1 recurs after 6 cycles.
REQ-042 lb/sb: op=100000 -> LBRD with iord=1, then LBWR with memtoreg=1 (8 cycles); op=101000 -> SBWR with memwrite=1 (7 cycles).
REQ-043 Illegal op=111111 -> DECODE goes to FETCH1; regwrite and memwrite stay 0 throughout.
REQ-044 funct=101010 -> alucontrol=111; funct=000000 -> alucontrol=010.
